gigatron_ram_reader: RTL and testbench
======================================

GIGATRON_RAM_READER -- requirements
Module: gigatron_ram_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: width of the RAM address and of the start/length operands.
REQ-002 SHALL have port i_clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_start  input  1  request a burst read; sampled only in IDLE.
REQ-005 SHALL have port i_base  input  ADDR_WIDTH  first RAM address of the burst.
REQ-006 SHALL have port i_length  input  ADDR_WIDTH  byte count; 0 means empty burst.
REQ-007 SHALL have port o_ram_addr  output  ADDR_WIDTH  address to RAM; RAM registers it, data returns next cycle.
REQ-008 SHALL have port i_ram_data  input  8  RAM read data for the address presented in the previous cycle.
REQ-009 SHALL have port o_data  output  8  stream byte; o_valid  output  1; i_ready  input  1.
REQ-010 SHALL have port o_busy  output  1  burst in progress; o_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port o_checksum  output  8  running byte sum (see Configuration).

Function
REQ-012 SHALL implement states IDLE, RUN and DRAIN.
REQ-013 IDLE, i_start=1, i_length!=0 at cycle T: SHALL latch base/length and enter RUN at T+1.
REQ-014 IDLE, i_start=1, i_length=0: SHALL pulse o_done at T+1, issue no reads, keep o_busy=0.
REQ-015 o_busy SHALL be 1 in RUN and DRAIN, 0 in IDLE.
REQ-016 In RUN, a read is issued in a cycle by driving o_ram_addr=ptr, then ptr+1; the RAM data SHALL be written into a 2-entry output FIFO at the end of the following cycle.
REQ-017 A read SHALL issue only when (fifo_count + inflight - pop) < 2, where pop = o_valid & i_ready in that cycle.
REQ-018 With i_ready held 1, throughput SHALL be one byte per cycle; first o_valid at T+3 after the start cycle T.
REQ-019 Address increment SHALL wrap modulo 2^ADDR_WIDTH (0xFFFF -> 0x0000).
REQ-020 RUN SHALL go to DRAIN after the cycle issuing the last read; DRAIN SHALL go to IDLE in the cycle after the final byte handshake.
REQ-021 o_done SHALL pulse for exactly one cycle, the cycle after the final byte handshake, coincident with return to IDLE.
REQ-022 o_data/o_valid SHALL come from the FIFO head; o_data SHALL be stable while o_valid=1 and i_ready=0.
REQ-023 i_start while o_busy=1 SHALL be ignored.
REQ-024 o_ram_addr SHALL hold its last value when no read issues.
REQ-025 Bytes SHALL be delivered in ascending address order with no loss or duplication under arbitrary i_ready patterns.

Reset
REQ-026 Reset SHALL force IDLE, flush FIFO and in-flight read, and set o_valid=0, o_busy=0, o_done=0, o_ram_addr=0, o_data=0, o_checksum=0.
REQ-027 Reset mid-burst SHALL abort without an o_done pulse; data arriving from a pre-reset read SHALL be discarded.

Configuration
REQ-028 Macro GIGATRON_RAM_READER_CHECKSUM_EN defined: o_checksum SHALL clear to 0 on an accepted i_start and add each handshaken byte modulo 256, holding after o_done until next start.
REQ-029 Macro undefined: o_checksum SHALL be constant 0 and no checksum logic SHALL be present.

Verification
REQ-030 RAM[0x0100..0x0103]=11,22,33,44; start base=0x0100 len=4, i_ready=1 -> o_valid at T+3..T+6 bytes 11,22,33,44, o_done at T+7, checksum 0xAA.
REQ-031 base=0xFFFE len=4 -> o_ram_addr sequence FFFE,FFFF,0000,0001; bytes delivered in that order.
REQ-032 len=8, i_ready toggled 1,0,0,1 repeating -> all 8 bytes exact order, o_data stable during stalls, FIFO never exceeds 2.
REQ-033 len=0 -> o_done at T+1, o_busy stays 0, o_ram_addr unchanged, o_valid never asserted.
REQ-034 len=16, reset asserted after 5 handshakes -> next cycle IDLE, o_valid=0, no o_done; new start len=2 completes normally.
REQ-035 i_start pulsed with len=3 while busy mid-burst -> ignored; only original burst bytes delivered, single o_done.

Source files
------------

// File: rtl/gigatron_ram_reader.sv
// gigatron_ram_reader
//   Reads a burst of bytes from a synchronous RAM that has one cycle of read
//   latency, and streams them out over a valid/ready handshake. A 2-entry
//   output FIFO with an in-flight read counter lets the stream run at one
//   byte per cycle and still stop cleanly under back-pressure.
//
// Ports
//   i_clock      clock, rising edge
//   i_reset      synchronous, active-high reset
//   i_start      burst request, sampled only in IDLE
//   i_base       first RAM address of the burst
//   i_length     byte count (0 = empty burst, completes with a bare o_done)
//   o_ram_addr   RAM address; the RAM registers it, data returns next cycle
//   i_ram_data   RAM data for the address presented in the previous cycle
//   o_data       stream byte (FIFO head)
//   o_valid      stream valid
//   i_ready      stream ready
//   o_busy       burst in progress (RUN or DRAIN)
//   o_done       one-cycle pulse, coincident with the return to IDLE
//   o_checksum   running mod-256 byte sum when GIGATRON_RAM_READER_CHECKSUM_EN
//                is defined, otherwise constant 0
module gigatron_ram_reader #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH-1:0] i_length,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  input  logic [7:0]            i_ram_data,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [7:0]            o_checksum
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] rem;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic                  inflight;   // read issued last cycle, data on i_ram_data now
  logic [7:0]            fifo [2];
  logic                  wr_idx;
  logic                  rd_idx;
  logic [1:0]            count;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occ_after;

  assign o_valid   = (count != 2'd0);
  assign o_data    = fifo[rd_idx];
  assign pop       = o_valid & i_ready;
  assign o_busy    = (state != IDLE);

  // Occupancy once this cycle's pop and the arriving read are accounted for.
  // A new read is only allowed if its data is guaranteed a FIFO slot.
  assign occ_after = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == RUN) && (rem != '0) && (occ_after < 3'd2);

  // The address is presented combinationally in the issuing cycle; otherwise
  // the previous address is held so the RAM sees a stable bus.
  assign o_ram_addr = issue ? ptr : addr_hold;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      ptr       <= '0;
      rem       <= '0;
      addr_hold <= '0;
      inflight  <= 1'b0;
      fifo[0]   <= '0;
      fifo[1]   <= '0;
      wr_idx    <= 1'b0;
      rd_idx    <= 1'b0;
      count     <= 2'd0;
      o_done    <= 1'b0;
    end else begin
      o_done    <= 1'b0;
      addr_hold <= o_ram_addr;
      inflight  <= issue;
      if (inflight) begin
        fifo[wr_idx] <= i_ram_data;
        wr_idx       <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      count <= count + {1'b0, inflight} - {1'b0, pop};
      if (issue) begin
        ptr <= ptr + ONE;   // wraps naturally at 2^ADDR_WIDTH
        rem <= rem - ONE;
      end
      case (state)
        IDLE: if (i_start) begin
          if (i_length != '0) begin
            ptr   <= i_base;
            rem   <= i_length;
            state <= RUN;
          end else begin
            o_done <= 1'b1;
          end
        end
        RUN: if (issue && rem == ONE) state <= DRAIN;
        // Last byte: one entry left, nothing in flight, and it is being taken.
        DRAIN: if (pop && count == 2'd1 && !inflight) begin
          state  <= IDLE;
          o_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GIGATRON_RAM_READER_CHECKSUM_EN
  logic [7:0] csum;

  // No pop can happen in IDLE (FIFO is empty there), so start-clear and
  // accumulate never collide.
  always_ff @(posedge i_clock) begin
    if (i_reset)                       csum <= '0;
    else if (state == IDLE && i_start) csum <= '0;
    else if (pop)                      csum <= csum + o_data;
  end

  assign o_checksum = csum;
`else
  assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_gigatron_ram_reader.sv
module tb_gigatron_ram_reader;
  localparam int AW = 16;

  logic          i_clock = 1'b0;
  logic          i_reset, i_start, i_ready;
  logic [AW-1:0] i_base, i_length, o_ram_addr;
  logic [7:0]    i_ram_data, o_data, o_checksum;
  logic          o_valid, o_busy, o_done;

  logic [7:0]    mem [0:65535];
  int            n_chk  = 0;
  int            n_fail = 0;
  int            got, dones;
  logic [7:0]    exp_sum;
  logic [15:0]   a16;
  logic [15:0]   wrap_addr [1:4];

  gigatron_ram_reader #(.ADDR_WIDTH(AW)) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_base     (i_base),
    .i_length   (i_length),
    .o_ram_addr (o_ram_addr),
    .i_ram_data (i_ram_data),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_checksum (o_checksum)
  );

  always #5 i_clock = ~i_clock;

  // Synchronous RAM model: one cycle of read latency.
  always_ff @(posedge i_clock) i_ram_data <= mem[o_ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one burst from IDLE. Inputs change and outputs are sampled at the
  // falling edge. stall applies ready pattern 1,0,0,1; inj>0 pulses a stray
  // start (len 3) in that cycle; rst_after>0 resets after that many handshakes.
  task automatic burst(input logic [15:0] base, input logic [15:0] len, input bit stall,
                       input int inj, input int rst_after, output int n_got, output int n_done);
    logic [3:0]  pat;
    logic [7:0]  prev;
    logic [15:0] a;
    bit          prev_stall;
    int          tail;
    pat = 4'b1001;
    n_got = 0; n_done = 0; prev_stall = 0; prev = '0; tail = -1;
    i_start = 1'b1; i_base = base; i_length = len;
    i_ready = stall ? pat[0] : 1'b1;
    for (int c = 1; c < 400 && tail != 0; c++) begin
      @(negedge i_clock);
      i_start = (c == inj);
      if (c == inj) begin i_base = 16'h0300; i_length = 16'd3; end
      i_ready = stall ? pat[c % 4] : 1'b1;
      if (o_done) n_done++;
      if (prev_stall) chk("stall_hold", {24'd0, o_data}, {24'd0, prev});
      if (o_valid && i_ready) begin
        a = base + n_got[15:0];
        chk("byte", {24'd0, o_data}, {24'd0, mem[a]});
        n_got++;
      end
      prev_stall = o_valid && !i_ready;
      prev = o_data;
      if (tail > 0) tail--;
      if (o_done && tail < 0) tail = 6;
      if (rst_after > 0 && n_got == rst_after) begin
        @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_busy",  {31'd0, o_busy},  32'd0);
        chk("rst_done",  {31'd0, o_done},  32'd0);
        repeat (4) begin
          @(negedge i_clock);
          if (o_done) n_done++;
          chk("post_rst_valid", {31'd0, o_valid}, 32'd0);
        end
        break;
      end
    end
    i_start = 1'b0;
    i_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      a16 = i[15:0];
      mem[i] = a16[7:0] + a16[15:8] * 8'd37 + 8'h11;
    end
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
    mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
`ifdef GIGATRON_RAM_READER_CHECKSUM_EN
    exp_sum = 8'hAA;
`else
    exp_sum = 8'h00;
`endif

    // Reset state
    i_reset = 1'b1; i_start = 1'b0; i_base = '0; i_length = '0; i_ready = 1'b1;
    repeat (2) @(negedge i_clock);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_busy",  {31'd0, o_busy},  32'd0);
    chk("reset_done",  {31'd0, o_done},  32'd0);
    chk("reset_addr",  {16'd0, o_ram_addr}, 32'd0);
    chk("reset_data",  {24'd0, o_data}, 32'd0);
    chk("reset_csum",  {24'd0, o_checksum}, 32'd0);
    i_reset = 1'b0;
    @(negedge i_clock);

    // Basic 4-byte burst at 0x0100, exact cycle timing
    i_start = 1'b1; i_base = 16'h0100; i_length = 16'd4;
    @(negedge i_clock); i_start = 1'b0;                       // T+1
    chk("b4_busy", {31'd0, o_busy}, 32'd1);
    chk("b4_addr1", {16'd0, o_ram_addr}, 32'h0100);
    chk("b4_valid1", {31'd0, o_valid}, 32'd0);
    @(negedge i_clock);                                       // T+2
    chk("b4_addr2", {16'd0, o_ram_addr}, 32'h0101);
    chk("b4_valid2", {31'd0, o_valid}, 32'd0);
    @(negedge i_clock);                                       // T+3
    chk("b4_valid3", {31'd0, o_valid}, 32'd1);
    chk("b4_d0", {24'd0, o_data}, 32'h11);
    @(negedge i_clock); chk("b4_d1", {24'd0, o_data}, 32'h22);
    @(negedge i_clock); chk("b4_d2", {24'd0, o_data}, 32'h33);
    @(negedge i_clock);                                       // T+6
    chk("b4_d3", {24'd0, o_data}, 32'h44);
    chk("b4_nodone", {31'd0, o_done}, 32'd0);
    @(negedge i_clock);                                       // T+7
    chk("b4_done", {31'd0, o_done}, 32'd1);
    chk("b4_idle", {31'd0, o_busy}, 32'd0);
    chk("b4_valid7", {31'd0, o_valid}, 32'd0);
    chk("b4_csum", {24'd0, o_checksum}, {24'd0, exp_sum});
    @(negedge i_clock);
    chk("b4_done_1cyc", {31'd0, o_done}, 32'd0);

    // Address wrap at the top of memory
    wrap_addr[1] = 16'hFFFE; wrap_addr[2] = 16'hFFFF;
    wrap_addr[3] = 16'h0000; wrap_addr[4] = 16'h0001;
    i_start = 1'b1; i_base = 16'hFFFE; i_length = 16'd4;
    for (int k = 1; k <= 7; k++) begin
      @(negedge i_clock); i_start = 1'b0;
      if (k <= 4) chk("wrap_addr", {16'd0, o_ram_addr}, {16'd0, wrap_addr[k]});
      if (k >= 3 && k <= 6) begin
        chk("wrap_valid", {31'd0, o_valid}, 32'd1);
        chk("wrap_data", {24'd0, o_data}, {24'd0, mem[wrap_addr[k-2]]});
      end
      if (k == 7) chk("wrap_done", {31'd0, o_done}, 32'd1);
    end

    // Empty burst: bare done, no reads, address held
    i_start = 1'b1; i_base = 16'h0400; i_length = 16'd0;
    @(negedge i_clock); i_start = 1'b0;
    chk("len0_done", {31'd0, o_done}, 32'd1);
    chk("len0_busy", {31'd0, o_busy}, 32'd0);
    chk("len0_valid", {31'd0, o_valid}, 32'd0);
    chk("len0_addr", {16'd0, o_ram_addr}, 32'h0001);
    chk("len0_csum", {24'd0, o_checksum}, 32'd0);
    @(negedge i_clock);
    chk("len0_done_off", {31'd0, o_done}, 32'd0);
    chk("len0_valid2", {31'd0, o_valid}, 32'd0);
    chk("len0_addr2", {16'd0, o_ram_addr}, 32'h0001);

    // Back-pressure pattern 1,0,0,1
    burst(16'h0200, 16'd8, 1'b1, 0, 0, got, dones);
    chk("stall_count", got, 32'd8);
    chk("stall_dones", dones, 32'd1);

    // Stray start while busy is ignored
    burst(16'h0500, 16'd6, 1'b0, 3, 0, got, dones);
    chk("busy_start_count", got, 32'd6);
    chk("busy_start_dones", dones, 32'd1);

    // Reset mid-burst, then a normal burst
    burst(16'h0600, 16'd16, 1'b0, 0, 5, got, dones);
    chk("abort_count", got, 32'd5);
    chk("abort_dones", dones, 32'd0);
    burst(16'h0700, 16'd2, 1'b0, 0, 0, got, dones);
    chk("after_rst_count", got, 32'd2);
    chk("after_rst_dones", dones, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
